// File: rtl/modmul_normalize_if.sv
// rtl/modmul_normalize_if.sv - operand/result handshake bundle for modmul_normalize
interface modmul_normalize_if #(
    parameter int NUM_ELEMENTS = 17,
    parameter int BIT_LEN      = 17
);
    logic                                 in_valid;
    logic                                 in_ready;
    logic [NUM_ELEMENTS-1:0][BIT_LEN-1:0] C;
    logic                                 out_valid;
    logic                                 out_ready;
    logic [NUM_ELEMENTS-1:0][BIT_LEN-1:0] R;
    logic                                 err;

    modport master (
        output in_valid, C, out_ready,
        input  in_ready, out_valid, R, err
    );

    modport slave (
        input  in_valid, C, out_ready,
        output in_ready, out_valid, R, err
    );
endinterface

// File: rtl/modmul_normalize.sv
// rtl/modmul_normalize.sv - word-serial carry propagation and bounded modular reduction
module modmul_normalize #(
    parameter int NUM_ELEMENTS = 17,
    parameter int BIT_LEN      = 17,
    parameter int WORD_LEN     = 16,
    parameter logic [WORD_LEN*(NUM_ELEMENTS-1)-1:0] MODULUS =
        256'hFFFFFFFEFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF00000000FFFFFFFFFFFFFFFF,
    parameter int MAX_SUB      = 4
) (
    input  logic              clk,
    input  logic              rst,
    modmul_normalize_if.slave bus
);
    localparam int MOD_W   = WORD_LEN * (NUM_ELEMENTS - 1);
    localparam int CARRY_W = BIT_LEN + 1 - WORD_LEN;
    localparam int ACC_W   = WORD_LEN * NUM_ELEMENTS + CARRY_W;
    localparam int IDX_W   = $clog2(NUM_ELEMENTS);
    localparam int CNT_W   = $clog2(MAX_SUB + 1);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ELEMENTS - 1);
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_SUB);
    localparam logic [ACC_W-1:0] MOD_EXT  = {{(ACC_W - MOD_W){1'b0}}, MODULUS};

    typedef enum logic [1:0] {IDLE, PROP, SUB, DONE} state_t;

    state_t                               state, state_nxt;
    logic [NUM_ELEMENTS-1:0][BIT_LEN-1:0] creg;
    logic [ACC_W-1:0]                     acc;
    logic [CARRY_W-1:0]                   carry;
    logic [IDX_W-1:0]                     idx;
    logic [CNT_W-1:0]                     cnt;
    logic [NUM_ELEMENTS-1:0][BIT_LEN-1:0] r_q;
    logic                                 err_q;

    logic [BIT_LEN:0] sum;
    logic             acc_ge;
    logic             can_sub;

    assign sum     = {1'b0, creg[idx]} + {{(BIT_LEN + 1 - CARRY_W){1'b0}}, carry};
    assign acc_ge  = (acc >= MOD_EXT);
    assign can_sub = acc_ge && (cnt < MAX_CNT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.in_valid)    state_nxt = PROP;
            PROP: if (idx == LAST_IDX) state_nxt = SUB;
            SUB:  if (!can_sub)        state_nxt = DONE;
            DONE: if (bus.out_ready)   state_nxt = IDLE;
            default:                   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            creg  <= '0;
            acc   <= '0;
            carry <= '0;
            idx   <= '0;
            cnt   <= '0;
            r_q   <= '0;
            err_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        creg  <= bus.C;
                        carry <= '0;
                        idx   <= '0;
                        cnt   <= '0;
                        err_q <= 1'b0;
                    end
                end
                PROP: begin
                    acc[int'(idx)*WORD_LEN +: WORD_LEN] <= sum[WORD_LEN-1:0];
                    carry <= sum[BIT_LEN -: CARRY_W];
                    idx   <= idx + 1'b1;
                    // The last word's carry-out becomes the accumulator's top bits
                    if (idx == LAST_IDX) begin
                        acc[ACC_W-1 -: CARRY_W] <= sum[BIT_LEN -: CARRY_W];
                    end
                end
                SUB: begin
                    if (can_sub) begin
                        acc <= acc - MOD_EXT;
                        cnt <= cnt + 1'b1;
                    end else begin
                        // Result is frozen here so R/err stay stable through any stall in DONE
                        err_q <= acc_ge;
                        for (int i = 0; i < NUM_ELEMENTS; i++) begin
                            r_q[i] <= {{(BIT_LEN - WORD_LEN){1'b0}}, acc[i*WORD_LEN +: WORD_LEN]};
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.R         = r_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_modmul_normalize.sv
// tb/tb_modmul_normalize.sv - scoreboard bench for modmul_normalize
module tb_modmul_normalize;
    localparam int NE   = 17;
    localparam int BL   = 17;
    localparam int WL   = 16;
    localparam int MAXS = 4;
    localparam int AW   = WL * NE + 2;
    localparam logic [255:0] P = 256'hFFFFFFFEFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF00000000FFFFFFFFFFFFFFFF;

    typedef logic [NE-1:0][BL-1:0] vec_t;
    typedef struct {
        vec_t r;
        logic err;
        int   lat;
        int   acc_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];
    exp_t mon_e;
    int   rise_cyc = 0;
    logic prev_ov = 1'b0;

    modmul_normalize_if #(.NUM_ELEMENTS(NE), .BIT_LEN(BL)) bus ();

    modmul_normalize dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [299:0] obs, input logic [299:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input vec_t c);
        exp_t e;
        logic [AW-1:0] v;
        logic [AW-1:0] p_ext;
        int k;
        v     = '0;
        k     = 0;
        p_ext = AW'(P);
        for (int i = 0; i < NE; i++) v = v + (AW'(c[i]) << (WL * i));
        while (v >= p_ext && k < MAXS) begin
            v = v - p_ext;
            k++;
        end
        e.err = (v >= p_ext);
        for (int i = 0; i < NE; i++) e.r[i] = {1'b0, v[WL*i +: WL]};
        e.lat     = NE + k + 1;
        e.acc_cyc = 0;
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            if (bus.out_valid && !prev_ov) rise_cyc = cyc;
            if (bus.out_valid) check("ready_valid_exclusive", bus.in_ready, 1'b0);
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    check("spurious_output", 1'b1, 1'b0);
                end else begin
                    mon_e = sb.pop_front();
                    check("err", bus.err, mon_e.err);
                    if (!mon_e.err) check("R", bus.R, mon_e.r);
                    check("latency", rise_cyc - mon_e.acc_cyc, mon_e.lat);
                end
            end
        end
        prev_ov = bus.out_valid;
    end

    task automatic send(input vec_t c, input bit track);
        exp_t e;
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            check("in_ready_timeout", 1'b0, 1'b1);
        end else begin
            bus.C        = c;
            bus.in_valid = 1'b1;
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            bus.C        = ~c;
            if (track) begin
                e         = model(c);
                e.acc_cyc = cyc;
                sb.push_back(e);
            end
        end
    endtask

    task automatic wait_out(input string tag);
        int n;
        n = 0;
        while (!bus.out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_out_valid_timeout"}, bus.out_valid, 1'b1);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_drain"}, sb.size(), 0);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        vec_t c;
        logic [255:0] pv;
        pv            = P;
        bus.in_valid  = 1'b0;
        bus.C         = '0;
        bus.out_ready = 1'b1;

        repeat (3) @(negedge clk);
        check("rst_in_ready", bus.in_ready, 1'b1);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_err", bus.err, 1'b0);
        check("rst_R", bus.R, '0);
        rst = 1'b1;

        c = '0;
        send(c, 1'b1);
        wait_out("zero");
        check("zero_in_ready_in_done", bus.in_ready, 1'b0);
        @(negedge clk);
        check("zero_in_ready_after_hs", bus.in_ready, 1'b1);

        c = '0;
        c[0] = 17'h1FFFF;
        send(c, 1'b1);

        c = '0;
        for (int i = 0; i < 16; i++) c[i] = {1'b0, pv[16*i +: 16]};
        send(c, 1'b1);

        c = '0;
        c[0] = 17'h10005;
        c[1] = 17'h1FFFF;
        send(c, 1'b1);

        for (int i = 0; i < NE; i++) c[i] = 17'h1FFFF;
        send(c, 1'b1);

        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < NE; i++) c[i] = BL'($urandom);
            c[NE-1] = '0;
            send(c, 1'b1);
        end
        wait_idle("basic");

        bus.out_ready = 1'b0;
        for (int i = 0; i < NE; i++) c[i] = BL'($urandom);
        c[NE-1] = 17'h1;
        send(c, 1'b1);
        wait_out("hold");
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            for (int i = 0; i < NE; i++) bus.C[i] = 17'h1FFFF;
            check("hold_out_valid", bus.out_valid, 1'b1);
            check("hold_in_ready", bus.in_ready, 1'b0);
            check("hold_err", bus.err, sb[0].err);
            if (!sb[0].err) check("hold_R", bus.R, sb[0].r);
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        wait_idle("hold");
        repeat (30) @(negedge clk);

        for (int i = 0; i < NE; i++) c[i] = BL'($urandom);
        send(c, 1'b0);
        repeat (5) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("abort_out_valid", bus.out_valid, 1'b0);
        check("abort_in_ready", bus.in_ready, 1'b1);
        check("abort_err", bus.err, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        repeat (30) @(negedge clk);

        c = '0;
        c[3] = 17'h1ABCD;
        c[16] = 17'h00001;
        send(c, 1'b1);
        wait_idle("post_reset");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
